// File: rtl/serial_to_parallel_128_pkg.sv
// ---------------------------------------------------------------------------
// serial_to_parallel_128_pkg
//
// Shared definitions for the serial-to-parallel word assembler:
//   S2P_WIDTH   - default assembled word width in bits
//   S2P_CNT_W   - width of the bit counter for the default word width
//   s2p_state_t - two-state FSM encoding (FILL collects bits, HOLD presents
//                 a completed word until downstream takes it)
// ---------------------------------------------------------------------------
package serial_to_parallel_128_pkg;

    localparam int S2P_WIDTH = 128;
    localparam int S2P_CNT_W = $clog2(S2P_WIDTH);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } s2p_state_t;

endpackage

// File: rtl/serial_to_parallel_128_bit_counter.sv
// ---------------------------------------------------------------------------
// bit_counter
//
// Counts bits accepted into the current partial word.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, clears the count
//   inc      - a bit is accepted this cycle
//   clr      - frame restart; when combined with inc the accepted bit
//              becomes bit 0 of the new word, so the count lands on 1
//   count    - bits accepted so far in the current word
//   terminal - count is WIDTH-1, i.e. the next accepted bit completes a word
// ---------------------------------------------------------------------------
module bit_counter #(
    parameter int WIDTH = 128,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          terminal
);

    assign terminal = (count == CW'(WIDTH - 1));

    // A clear takes priority over the old count; a simultaneous increment
    // is counted as the first bit of the restarted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CW'(1) : '0;
        end else if (inc) begin
            count <= terminal ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_to_parallel_128.sv
// ---------------------------------------------------------------------------
// serial_to_parallel_128
//
// Assembles a serial bit stream into WIDTH-bit words with ready/valid
// handshakes on both sides.
// Parameters:
//   WIDTH     - assembled word width
//   MSB_FIRST - 1: first accepted bit goes to par_out[WIDTH-1]
//               0: first accepted bit goes to par_out[0]
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   ser_in    - serial data bit
//   ser_valid - ser_in carries a bit this cycle
//   ser_ready - block accepts a bit this cycle (high while filling)
//   sync      - frame restart, discards the partial word (ignored in HOLD)
//   par_out   - assembled word
//   par_valid - par_out holds a complete word
//   par_ready - downstream consumes the word this cycle
//   bit_cnt   - bits accepted into the current partial word
// ---------------------------------------------------------------------------
module serial_to_parallel_128
    import serial_to_parallel_128_pkg::*;
#(
    parameter int WIDTH     = S2P_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ser_in,
    input  logic                     ser_valid,
    output logic                     ser_ready,
    input  logic                     sync,
    output logic [WIDTH-1:0]         par_out,
    output logic                     par_valid,
    input  logic                     par_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);

    s2p_state_t    state;
    s2p_state_t    state_next;
    logic          accept;
    logic          restart;
    logic          last_bit;
    logic          terminal;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wr_pos;
    logic [CW-1:0] wr_idx;

    assign ser_ready = (state == FILL);
    assign par_valid = (state == HOLD);
    assign accept    = ser_valid & ser_ready;
    assign restart   = sync & (state == FILL);
    assign bit_cnt   = cnt;

    // A restart in the same cycle as an accept places the bit at position 0,
    // so the word cannot complete on a restart edge.
    assign wr_pos   = restart ? '0 : cnt;
    assign last_bit = accept & ~restart & terminal;

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (accept),
        .clr      (restart),
        .count    (cnt),
        .terminal (terminal)
    );

    // Bit position within par_out for the current accept.
    always_comb begin
        wr_idx = wr_pos;
        if (MSB_FIRST != 0) begin
            wr_idx = CW'(WIDTH - 1) - wr_pos;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // FILL moves to HOLD on the word's last bit; HOLD waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (last_bit) state_next = HOLD;
            HOLD:    if (par_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Only the addressed bit is written; others keep their previous values,
    // which also keeps the word stable while in HOLD (no accepts happen there).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_out <= '0;
        end else if (accept) begin
            par_out[wr_idx] <= ser_in;
        end
    end

endmodule
